// File: rtl/vector_addsub_pkg.sv
// Shared definitions for the streaming vector add/subtract block:
// mode encoding and sizing helpers for the beat counter.
package vector_addsub_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Number of beats needed to carry one vector.
  function automatic int beats_of(input int vec_len, input int lanes);
    return vec_len / lanes;
  endfunction

  // Beat counter width; a single-beat vector still gets a 1-bit counter.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/vector_lane_addsub.sv
// One lane of the vector adder/subtractor: sign-extend, add or subtract,
// and (with VADD_SAT_EN defined) clamp to the IN_WIDTH signed range.
// The clamp bit reports whether this lane's result was clamped.
module vector_lane_addsub
  import vector_addsub_pkg::*;
#(
  parameter int IN_WIDTH = 14
) (
  input  logic [IN_WIDTH-1:0] a,
  input  logic [IN_WIDTH-1:0] b,
  input  mode_e               mode,
  output logic [IN_WIDTH:0]   s,
  output logic                clamp
);

  logic [IN_WIDTH:0] ax, bx, raw;

  assign ax = {a[IN_WIDTH-1], a};
  assign bx = {b[IN_WIDTH-1], b};

  // One extra bit of headroom makes the add/subtract exact.
  always_comb begin
    raw = (mode == MODE_SUB) ? (ax - bx) : (ax + bx);
  end

`ifdef VADD_SAT_EN
  // Result is out of IN_WIDTH range when the top two bits disagree;
  // the top bit then tells which rail to clamp to.
  always_comb begin
    clamp = raw[IN_WIDTH] ^ raw[IN_WIDTH-1];
    s     = raw;
    if (clamp)
      s = raw[IN_WIDTH] ? {2'b11, {(IN_WIDTH-1){1'b0}}}
                        : {2'b00, {(IN_WIDTH-1){1'b1}}};
  end
`else
  assign s     = raw;
  assign clamp = 1'b0;
`endif

endmodule

// File: rtl/vector_addsub_stream.sv
// Streaming vector adder/subtractor. A VEC_LEN-element vector arrives as
// VEC_LEN/LANES beats; the mode is captured on beat 0 and reused for the
// rest of the vector. Two register stages (operands, then results), both
// frozen by output backpressure or by enable low.
// Optional saturation: define VADD_SAT_EN to clamp lanes and drive satFlag.
module vector_addsub_stream
  import vector_addsub_pkg::*;
#(
  parameter int IN_WIDTH = 14,
  parameter int LANES    = 4,
  parameter int VEC_LEN  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        inReady,
  output logic                        inAccept,
  input  logic                        inMode,
  input  logic [LANES*IN_WIDTH-1:0]   A,
  input  logic [LANES*IN_WIDTH-1:0]   B,
  output logic                        outReady,
  input  logic                        outAccept,
  output logic [LANES*(IN_WIDTH+1)-1:0] S,
  output logic                        outLast,
  output logic                        earlyOutReady,
  input  logic                        satClear,
  output logic                        satFlag
);

  localparam int OW    = IN_WIDTH + 1;
  localparam int BEATS = beats_of(VEC_LEN, LANES);
  localparam int CW    = cnt_width(BEATS);

  // handshake
  logic stall, adv, take;

  // beat counter and captured mode
  logic [CW-1:0] cnt;
  mode_e         mode_q;
  logic          first_beat, last_beat;
  mode_e         eff_mode;

  // stage 1
  logic                      v1;
  logic [LANES*IN_WIDTH-1:0] a1, b1;
  mode_e                     mode1;
  logic                      last1;

  // stage 2
  logic                 v2;
  logic [LANES*OW-1:0]  s_q;
  logic                 last2;

  // lane results
  logic [LANES*OW-1:0]  lane_s;
  logic [LANES-1:0]     lane_clamp;

  assign stall    = v2 & ~outAccept;
  assign adv      = enable & ~stall;
  assign inAccept = adv;
  assign take     = inReady & adv;

  assign first_beat = (cnt == '0);
  assign last_beat  = (cnt == CW'(BEATS - 1));
  assign eff_mode   = first_beat ? mode_e'(inMode) : mode_q;

  // Beat position within the vector and the mode captured on beat 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      mode_q <= MODE_ADD;
    end else if (take) begin
      cnt <= last_beat ? '0 : cnt + 1'b1;
      if (first_beat) mode_q <= mode_e'(inMode);
    end
  end

  // Two-stage pipeline; both stages move together only when not stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      mode1 <= MODE_ADD;
      last1 <= 1'b0;
      v2    <= 1'b0;
      s_q   <= '0;
      last2 <= 1'b0;
    end else if (adv) begin
      v1 <= take;
      if (take) begin
        a1    <= A;
        b1    <= B;
        mode1 <= eff_mode;
        last1 <= last_beat;
      end
      v2    <= v1;
      last2 <= v1 & last1;
      if (v1) s_q <= lane_s;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vector_lane_addsub #(.IN_WIDTH(IN_WIDTH)) u_lane (
      .a     (a1[i*IN_WIDTH +: IN_WIDTH]),
      .b     (b1[i*IN_WIDTH +: IN_WIDTH]),
      .mode  (mode1),
      .s     (lane_s[i*OW +: OW]),
      .clamp (lane_clamp[i])
    );
  end

  assign outReady      = v2;
  assign S             = s_q;
  assign outLast       = last2;
  assign earlyOutReady = v1;

`ifdef VADD_SAT_EN
  logic clamp2, sat_q;

  // Remember whether the beat now in stage 2 was clamped on any lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             clamp2 <= 1'b0;
    else if (adv && v1)    clamp2 <= |lane_clamp;
  end

  // Sticky flag: set when a clamped beat leaves the block; set beats clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else if (enable) begin
      if (v2 && outAccept && clamp2) sat_q <= 1'b1;
      else if (satClear)             sat_q <= 1'b0;
    end
  end

  assign satFlag = sat_q;
`else
  logic unused_sat;
  assign unused_sat = satClear ^ (|lane_clamp);
  assign satFlag    = 1'b0;
`endif

endmodule

// File: tb/tb_vector_addsub_stream.sv
// Self-checking bench for vector_addsub_stream (IN_WIDTH=14, LANES=4,
// VEC_LEN=16). A scoreboard process models each accepted beat with plain
// integer arithmetic and compares every delivered beat; scenario tasks add
// directed checks for latency, stalls, enable, reset and saturation.
module tb_vector_addsub_stream;

  localparam int W     = 14;
  localparam int L     = 4;
  localparam int VL    = 16;
  localparam int BEATS = VL / L;
  localparam int OW    = W + 1;
  localparam int VMAX  = (1 << (W - 1)) - 1;
  localparam int VMIN  = -(1 << (W - 1));

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            inReady;
  logic            inAccept;
  logic            inMode;
  logic [L*W-1:0]  A, B;
  logic            outReady;
  logic            outAccept;
  logic [L*OW-1:0] S;
  logic            outLast;
  logic            earlyOutReady;
  logic            satClear;
  logic            satFlag;

  int checks = 0;
  int errors = 0;

  vector_addsub_stream #(.IN_WIDTH(W), .LANES(L), .VEC_LEN(VL)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .inReady(inReady), .inAccept(inAccept), .inMode(inMode),
    .A(A), .B(B),
    .outReady(outReady), .outAccept(outAccept), .S(S), .outLast(outLast),
    .earlyOutReady(earlyOutReady), .satClear(satClear), .satFlag(satFlag)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [L*OW-1:0] s;
    logic            last;
  } exp_t;

  exp_t expq[$];
  int   mcnt   = 0;
  bit   mmode  = 1'b0;
  int   ndeliv = 0;
  int   nlast  = 0;

  function automatic logic [L*W-1:0] repw(input int v);
    logic [L*W-1:0] r;
    for (int i = 0; i < L; i++) r[i*W +: W] = v[W-1:0];
    return r;
  endfunction

  function automatic logic [L*OW-1:0] repo(input int v);
    logic [L*OW-1:0] r;
    for (int i = 0; i < L; i++) r[i*OW +: OW] = v[OW-1:0];
    return r;
  endfunction

  function automatic logic [L*OW-1:0] ref_sum(input logic [L*W-1:0] a,
                                              input logic [L*W-1:0] b,
                                              input bit m);
    logic [L*OW-1:0] r;
    int x, y, z;
    for (int i = 0; i < L; i++) begin
      x = int'($signed(a[i*W +: W]));
      y = int'($signed(b[i*W +: W]));
      z = m ? (x - y) : (x + y);
`ifdef VADD_SAT_EN
      if (z > VMAX) z = VMAX;
      if (z < VMIN) z = VMIN;
`endif
      r[i*OW +: OW] = z[OW-1:0];
    end
    return r;
  endfunction

  function automatic logic [L*W-1:0] rnd_vec();
    logic [L*W-1:0] r;
    int v;
    for (int i = 0; i < L; i++) begin
      case ($urandom_range(0, 3))
        0:       v = VMIN;
        1:       v = VMAX;
        default: v = int'($urandom_range(0, 16383)) - 8192;
      endcase
      r[i*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  // Scoreboard: inputs change just after posedge, so the negedge sees the
  // exact handshake values the next posedge will act on.
  always @(negedge clk) begin
    exp_t e;
    bit   m;
    if (reset) begin
      expq.delete();
      mcnt = 0;
    end else begin
      checks++;
      if (inAccept !== (enable & ~(outReady & ~outAccept))) begin
        errors++;
        $display("FAIL inAccept_rule: got %b need %b", inAccept,
                 enable & ~(outReady & ~outAccept));
      end
      if (enable && outReady && outAccept) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got S=%h with no beat pending", S);
        end else begin
          e = expq.pop_front();
          if (S !== e.s || outLast !== e.last) begin
            errors++;
            $display("FAIL beat_data: got S=%h last=%b need S=%h last=%b",
                     S, outLast, e.s, e.last);
          end
        end
        ndeliv++;
        if (outLast) nlast++;
      end
      if (inReady && inAccept) begin
        if (mcnt == 0) mmode = inMode;
        m      = mmode;
        e.s    = ref_sum(A, B, m);
        e.last = (mcnt == BEATS - 1);
        expq.push_back(e);
        mcnt = (mcnt + 1) % BEATS;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; inReady = 1'b0; satClear = 1'b0; enable = 1'b1; outAccept = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic drain();
    inReady = 1'b0; enable = 1'b1; outAccept = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (expq.size() == 0 && !outReady && !earlyOutReady) break;
      tick();
    end
    checks++;
    if (expq.size() != 0 || outReady !== 1'b0) begin
      errors++;
      $display("FAIL drain: got %0d beats pending outReady=%b need 0 and 0",
               expq.size(), outReady);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; inReady = 1'b0; inMode = 1'b0;
    A = '0; B = '0; outAccept = 1'b1; satClear = 1'b0;
    tick(); tick();
    checks++;
    if (S !== '0 || outReady !== 1'b0 || outLast !== 1'b0 ||
        earlyOutReady !== 1'b0 || satFlag !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got S=%h r=%b l=%b e=%b f=%b need all 0",
               S, outReady, outLast, earlyOutReady, satFlag);
    end
    reset = 1'b0; enable = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    outAccept = 1'b1; inMode = 1'b0;
    A = repw(VMAX); B = repw(VMAX);
    for (int k = 0; k < 6; k++) begin
      inReady = (k < 4);
      tick();
      checks++;
      if (earlyOutReady !== (k < 4) || outReady !== (k >= 1 && k <= 4) ||
          outLast !== (k == 4)) begin
        errors++;
        $display("FAIL latency_k%0d: got e=%b r=%b l=%b need e=%b r=%b l=%b", k,
                 earlyOutReady, outReady, outLast, k < 4, k >= 1 && k <= 4, k == 4);
      end
      if (k >= 1 && k <= 4) begin
        checks++;
        if (S !== repo(16382)) begin
          errors++;
          $display("FAIL max_sum_k%0d: got %h need %h", k, S, repo(16382));
        end
      end
    end
    drain();
  endtask

  task automatic test_mode_latch();
    logic [L*OW-1:0] want;
    outAccept = 1'b1;
    for (int k = 0; k < 5; k++) begin
      inReady = (k < 4);
      inMode  = (k == 0);
      A = (k == 0) ? repw(VMIN) : repw(100);
      B = (k == 0) ? repw(VMAX) : repw(30);
      tick();
      if (k >= 1) begin
        want = (k == 1) ? repo(-16383) : repo(70);
        checks++;
        if (outReady !== 1'b1 || S !== want) begin
          errors++;
          $display("FAIL mode_latch_k%0d: got r=%b S=%h need r=1 S=%h", k, outReady, S, want);
        end
      end
    end
    drain();
  endtask

  task automatic test_stall();
    int sent = 0, d0 = ndeliv, l0 = nlast;
    logic [L*OW-1:0] hold;
    for (int c = 0; c < 40 && sent < 8; c++) begin
      inReady   = 1'b1;
      A         = rnd_vec();
      B         = rnd_vec();
      inMode    = 1'($urandom);
      outAccept = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (inAccept !== 1'b0 || outReady !== 1'b1) begin
          errors++;
          $display("FAIL stall_accept_c%0d: got acc=%b r=%b need acc=0 r=1", c, inAccept, outReady);
        end
        if (c == 3) hold = S;
        else begin
          checks++;
          if (S !== hold) begin
            errors++;
            $display("FAIL stall_hold_c%0d: got %h need %h", c, S, hold);
          end
        end
      end
      if (inAccept) sent++;
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (ndeliv - d0 != 8 || nlast - l0 != 2) begin
      errors++;
      $display("FAIL stall_count: got %0d beats %0d last need 8 beats 2 last",
               ndeliv - d0, nlast - l0);
    end
  endtask

  task automatic test_enable();
    int d0 = ndeliv, l0 = nlast;
    logic [L*OW-1:0] s_snap;
    logic [2:0]      f_snap;
    outAccept = 1'b1;
    for (int c = 0; c < 6; c++) begin
      enable  = !(c == 2 || c == 3);
      inReady = 1'b1;
      A = rnd_vec(); B = rnd_vec(); inMode = 1'($urandom);
      #1;
      if (c == 2) begin
        s_snap = S; f_snap = {outReady, outLast, earlyOutReady};
      end
      if (c == 2 || c == 3) begin
        checks++;
        if (inAccept !== 1'b0) begin
          errors++;
          $display("FAIL enable_accept_c%0d: got %b need 0", c, inAccept);
        end
      end
      if (c == 3 || c == 4) begin
        checks++;
        if (S !== s_snap || {outReady, outLast, earlyOutReady} !== f_snap) begin
          errors++;
          $display("FAIL enable_hold_c%0d: got S=%h f=%b need S=%h f=%b", c, S,
                   {outReady, outLast, earlyOutReady}, s_snap, f_snap);
        end
      end
      @(posedge clk); #1;
    end
    drain();
    checks++;
    if (ndeliv - d0 != 4 || nlast - l0 != 1) begin
      errors++;
      $display("FAIL enable_count: got %0d beats %0d last need 4 beats 1 last",
               ndeliv - d0, nlast - l0);
    end
  endtask

  task automatic test_reset_mid();
    int l0;
    outAccept = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inReady = 1'b1; inMode = 1'b1; A = rnd_vec(); B = rnd_vec();
      tick();
    end
    inReady = 1'b0;
    reset   = 1'b1;
    #1;
    checks++;
    if (S !== '0 || outReady !== 1'b0 || outLast !== 1'b0 || earlyOutReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got S=%h r=%b l=%b e=%b need all 0",
               S, outReady, outLast, earlyOutReady);
    end
    tick();
    reset = 1'b0;
    tick();
    l0 = nlast;
    for (int k = 0; k < 5; k++) begin
      inReady = (k < 4);
      inMode  = (k != 0);
      A = (k == 0) ? repw(1000) : rnd_vec();
      B = (k == 0) ? repw(24)   : rnd_vec();
      tick();
      if (k == 1) begin
        checks++;
        if (outReady !== 1'b1 || S !== repo(1024)) begin
          errors++;
          $display("FAIL reset_fresh_mode: got r=%b S=%h need r=1 S=%h", outReady, S, repo(1024));
        end
      end
    end
    drain();
    checks++;
    if (nlast - l0 != 1) begin
      errors++;
      $display("FAIL reset_last: got %0d last need 1", nlast - l0);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      inReady   = ($urandom_range(0, 3) != 0);
      outAccept = ($urandom_range(0, 9) < 7);
      inMode    = 1'($urandom);
      A = rnd_vec(); B = rnd_vec();
      tick();
    end
    drain();
  endtask

  task automatic test_sat();
    do_reset();
    inMode = 1'b0; A = repw(VMAX); B = repw(1);
    inReady = 1'b1; tick();
    inReady = 1'b0; tick();
    checks++;
`ifdef VADD_SAT_EN
    if (outReady !== 1'b1 || S !== repo(VMAX)) begin
      errors++;
      $display("FAIL sat_value: got r=%b S=%h need r=1 S=%h", outReady, S, repo(VMAX));
    end
`else
    if (outReady !== 1'b1 || S !== repo(8192)) begin
      errors++;
      $display("FAIL exact_value: got r=%b S=%h need r=1 S=%h", outReady, S, repo(8192));
    end
`endif
    tick();
    checks++;
`ifdef VADD_SAT_EN
    if (satFlag !== 1'b1) begin
      errors++;
      $display("FAIL sat_set: got %b need 1", satFlag);
    end
    enable = 1'b0; satClear = 1'b1; tick();
    checks++;
    if (satFlag !== 1'b1) begin
      errors++;
      $display("FAIL sat_enable_hold: got %b need 1", satFlag);
    end
    enable = 1'b1; tick();
    satClear = 1'b0;
    checks++;
    if (satFlag !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: got %b need 0", satFlag);
    end
`else
    if (satFlag !== 1'b0) begin
      errors++;
      $display("FAIL sat_tied: got %b need 0", satFlag);
    end
`endif
    // Clear requested on the same edge a clamped beat leaves: set wins.
    inReady = 1'b1; tick();
    inReady = 1'b0; tick();
    satClear = 1'b1; tick();
    satClear = 1'b0;
    checks++;
`ifdef VADD_SAT_EN
    if (satFlag !== 1'b1) begin
      errors++;
      $display("FAIL sat_set_wins: got %b need 1", satFlag);
    end
`else
    if (satFlag !== 1'b0) begin
      errors++;
      $display("FAIL sat_tied_clear: got %b need 0", satFlag);
    end
`endif
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_mode_latch();
    test_stall();
    test_enable();
    test_reset_mid();
    test_random();
    test_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
